// File: rtl/fp_mult_if.sv
// Streaming handshake bundle for the pipelined floating-point multiplier.
// The producer drives operands and out_ready; the multiplier drives results.
interface fp_mult_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 8
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_result;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_flags
    );
endinterface

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier (unpack / multiply / round)
// with round-to-nearest-even, DAZ/FTZ and {invalid, overflow, underflow, inexact}.
// Stages carry a valid bit each; bubbles collapse and backpressure ripples back
// combinationally from out_ready to in_ready.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 8
) (
    input logic      clk,
    input logic      rst,
    fp_mult_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS   = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [EW-1:0] E_MAX  = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EW-1:0] E_ZERO = {EW{1'b0}};
    localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Operand class as {zero_or_subnormal, inf, nan, snan}.
    function automatic logic [3:0] classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        logic             e_max;
        e       = x[W-2:MAN_W];
        f       = x[MAN_W-1:0];
        e_max   = &e;
        classify = {(e == {EXP_W{1'b0}}),
                    e_max & (f == {MAN_W{1'b0}}),
                    e_max & (f != {MAN_W{1'b0}}),
                    e_max & (f != {MAN_W{1'b0}}) & ~f[MAN_W-1]};
    endfunction

    // Handshake: a stage loads when empty or when its contents move on.
    logic v1_q, v2_q, v3_q;
    logic load1, load2, load3;
    assign load3        = ~v3_q | bus.out_ready;
    assign load2        = ~v2_q | load3;
    assign load1        = ~v1_q | load2;
    assign bus.in_ready = load1;

    // Stage 1 next-state: classify operands, combine signs and exponents.
    logic [3:0]           cls_a, cls_b;
    logic                 sign1_d, nan1_d, inv1_d, inf1_d, zero1_d;
    logic signed [EW-1:0] exp1_d;
    logic [SW-1:0]        siga1_d, sigb1_d;

    // Unpack operands and resolve which special case (if any) applies.
    always_comb begin
        cls_a   = classify(bus.in_a);
        cls_b   = classify(bus.in_b);
        sign1_d = bus.in_a[W-1] ^ bus.in_b[W-1];
        exp1_d  = $signed({2'b00, bus.in_a[W-2:MAN_W]})
                + $signed({2'b00, bus.in_b[W-2:MAN_W]}) - BIAS;
        siga1_d = {1'b1, bus.in_a[MAN_W-1:0]};
        sigb1_d = {1'b1, bus.in_b[MAN_W-1:0]};
        inv1_d  = cls_a[0] | cls_b[0] | (cls_a[2] & cls_b[3]) | (cls_a[3] & cls_b[2]);
        nan1_d  = cls_a[1] | cls_b[1] | inv1_d;
        inf1_d  = cls_a[2] | cls_b[2];
        zero1_d = cls_a[3] | cls_b[3];
    end

    logic                 sign1_q, nan1_q, inv1_q, inf1_q, zero1_q;
    logic signed [EW-1:0] exp1_q;
    logic [SW-1:0]        siga1_q, sigb1_q;
    logic [TAG_W-1:0]     tag1_q;

    // Stage 1 register: capture unpacked operands on an input handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0; sign1_q <= 1'b0; nan1_q <= 1'b0; inv1_q <= 1'b0;
            inf1_q <= 1'b0; zero1_q <= 1'b0; exp1_q <= E_ZERO;
            siga1_q <= {SW{1'b0}}; sigb1_q <= {SW{1'b0}}; tag1_q <= {TAG_W{1'b0}};
        end else if (load1) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                sign1_q <= sign1_d; nan1_q <= nan1_d; inv1_q <= inv1_d;
                inf1_q <= inf1_d; zero1_q <= zero1_d; exp1_q <= exp1_d;
                siga1_q <= siga1_d; sigb1_q <= sigb1_d; tag1_q <= bus.in_tag;
            end
        end
    end

    logic [PW-1:0] prod2_d;
    assign prod2_d = {{SW{1'b0}}, siga1_q} * {{SW{1'b0}}, sigb1_q};

    logic                 sign2_q, nan2_q, inv2_q, inf2_q, zero2_q;
    logic signed [EW-1:0] exp2_q;
    logic [PW-1:0]        prod2_q;
    logic [TAG_W-1:0]     tag2_q;

    // Stage 2 register: significand product plus forwarded side information.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0; sign2_q <= 1'b0; nan2_q <= 1'b0; inv2_q <= 1'b0;
            inf2_q <= 1'b0; zero2_q <= 1'b0; exp2_q <= E_ZERO;
            prod2_q <= {PW{1'b0}}; tag2_q <= {TAG_W{1'b0}};
        end else if (load2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sign2_q <= sign1_q; nan2_q <= nan1_q; inv2_q <= inv1_q;
                inf2_q <= inf1_q; zero2_q <= zero1_q; exp2_q <= exp1_q;
                prod2_q <= prod2_d; tag2_q <= tag1_q;
            end
        end
    end

    // Stage 3 next-state: normalise, round, select special result.
    logic [PW-1:0]        norm;
    logic [SW-1:0]        sig;
    logic [SW:0]          sig_r;
    logic                 guard, sticky, rnd;
    logic signed [EW-1:0] e_norm, e_fin;
    logic [MAN_W-1:0]     frac;
    logic [W-1:0]         res3_d;
    logic [3:0]           flags3_d;

    // Normalise so the leading one sits at the product MSB, then apply RNE.
    always_comb begin
        norm   = prod2_q[PW-1] ? prod2_q : {prod2_q[PW-2:0], 1'b0};
        e_norm = exp2_q + $signed({{(EW-1){1'b0}}, prod2_q[PW-1]});
        sig    = norm[PW-1 -: SW];
        guard  = norm[MAN_W];
        sticky = |norm[MAN_W-1:0];
        rnd    = guard & (sticky | sig[0]);
        sig_r  = {1'b0, sig} + {{SW{1'b0}}, rnd};
        e_fin  = e_norm + $signed({{(EW-1){1'b0}}, sig_r[SW]});
        frac   = sig_r[SW] ? sig_r[SW-1:1] : sig_r[MAN_W-1:0];
        if (nan2_q) begin
            res3_d   = QNAN;
            flags3_d = {inv2_q, 3'b000};
        end else if (inf2_q) begin
            res3_d   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags3_d = 4'b0000;
        end else if (zero2_q) begin
            res3_d   = {sign2_q, {(W-1){1'b0}}};
            flags3_d = 4'b0000;
        end else if (e_fin >= E_MAX) begin
            res3_d   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags3_d = 4'b0101;
        end else if (e_fin <= E_ZERO) begin
            res3_d   = {sign2_q, {(W-1){1'b0}}};
            flags3_d = 4'b0011;
        end else begin
            res3_d   = {sign2_q, e_fin[EXP_W-1:0], frac};
            flags3_d = {3'b000, guard | sticky};
        end
    end

    logic [W-1:0]     res3_q;
    logic [3:0]       flags3_q;
    logic [TAG_W-1:0] tag3_q;

    // Stage 3 register: output holding register, frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q <= 1'b0; res3_q <= {W{1'b0}}; flags3_q <= 4'b0000; tag3_q <= {TAG_W{1'b0}};
        end else if (load3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                res3_q <= res3_d; flags3_q <= flags3_d; tag3_q <= tag2_q;
            end
        end
    end

    assign bus.out_valid  = v3_q;
    assign bus.out_result = res3_q;
    assign bus.out_tag    = tag3_q;
    assign bus.out_flags  = flags3_q;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed and randomised bench for fp_mult_pipe in FP32 and BF16 configurations.
module tb_fp_mult_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    fp_mult_if #(.EXP_W(8), .MAN_W(23), .TAG_W(8)) b32 ();
    fp_mult_if #(.EXP_W(8), .MAN_W(7),  .TAG_W(8)) b16 ();

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    fp_mult_pipe #(.EXP_W(8), .MAN_W(7),  .TAG_W(8)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp_v);
        end
    endtask

    task automatic set_in(input int cfg, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [7:0] t);
        if (cfg == 0) begin
            b32.in_valid = v; b32.in_a = a; b32.in_b = b; b32.in_tag = t;
        end else begin
            b16.in_valid = v; b16.in_a = a[15:0]; b16.in_b = b[15:0]; b16.in_tag = t;
        end
    endtask

    task automatic get_out(input int cfg, output logic ov, output logic [31:0] res,
                           output logic [7:0] tg, output logic [3:0] fl, output logic ir);
        if (cfg == 0) begin
            ov = b32.out_valid; res = b32.out_result; tg = b32.out_tag;
            fl = b32.out_flags; ir = b32.in_ready;
        end else begin
            ov = b16.out_valid; res = {16'h0000, b16.out_result}; tg = b16.out_tag;
            fl = b16.out_flags; ir = b16.in_ready;
        end
    endtask

    // Independent reference: exact integer product, rounding by remainder vs. half.
    function automatic logic [35:0] ref_mul(input int ew, input int mw,
                                            input logic [31:0] a, input logic [31:0] b);
        longint emax, bias, mmask, ea, eb, fa, fb, p, q, rem, half, e, s, res;
        int     k, sh;
        logic   za, zb, ia, ib, na, nb, sna, snb;
        logic [3:0] fl;
        emax  = (64'sd1 << ew) - 64'sd1;
        bias  = (64'sd1 << (ew - 1)) - 64'sd1;
        mmask = (64'sd1 << mw) - 64'sd1;
        ea = (longint'({32'h0, a}) >> mw) & emax;
        eb = (longint'({32'h0, b}) >> mw) & emax;
        fa = longint'({32'h0, a}) & mmask;
        fb = longint'({32'h0, b}) & mmask;
        s  = longint'(a[ew+mw] ^ b[ew+mw]);
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == emax) && (fa == 0); ib = (eb == emax) && (fb == 0);
        na = (ea == emax) && (fa != 0); nb = (eb == emax) && (fb != 0);
        sna = na && (((fa >> (mw - 1)) & 64'sd1) == 0);
        snb = nb && (((fb >> (mw - 1)) & 64'sd1) == 0);
        fl = 4'b0000;
        if (na || nb || (ia && zb) || (za && ib)) begin
            fl[3] = sna || snb || (ia && zb) || (za && ib);
            res = (emax << mw) | (64'sd1 << (mw - 1));
        end else if (ia || ib) begin
            res = (s << (ew + mw)) | (emax << mw);
        end else if (za || zb) begin
            res = s << (ew + mw);
        end else begin
            p  = ((64'sd1 << mw) | fa) * ((64'sd1 << mw) | fb);
            k  = ((p >> (2 * mw + 1)) != 0) ? 2 * mw + 1 : 2 * mw;
            e  = ea + eb - bias + longint'(k - 2 * mw);
            sh = k - mw;
            q    = p >> sh;
            rem  = p & ((64'sd1 << sh) - 64'sd1);
            half = 64'sd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'sd1;
            if (q == (64'sd1 << (mw + 1))) begin
                q = q >> 1;
                e = e + 64'sd1;
            end
            if (e >= emax) begin
                res = (s << (ew + mw)) | (emax << mw); fl = 4'b0101;
            end else if (e <= 0) begin
                res = s << (ew + mw); fl = 4'b0011;
            end else begin
                res = (s << (ew + mw)) | (e << mw) | (q & mmask);
                fl  = {3'b000, rem != 0};
            end
        end
        return {fl, res[31:0]};
    endfunction

    // One isolated operation with out_ready high; result expected three edges later.
    task automatic run_op(input int cfg, input string name, input logic [31:0] a,
                          input logic [31:0] b, input logic [7:0] t,
                          input logic [31:0] eres, input logic [3:0] efl);
        logic ov, ir; logic [31:0] r; logic [7:0] tg; logic [3:0] fl;
        set_in(cfg, 1'b1, a, b, t);
        tick();
        set_in(cfg, 1'b0, 32'h0, 32'h0, 8'h00);
        tick();
        tick();
        get_out(cfg, ov, r, tg, fl, ir);
        chk(name, {23'h0, ov, tg, fl, r}, {23'h0, 1'b1, t, efl, eres});
        tick();
    endtask

    task automatic rand_run(input int cfg, input int n);
        logic [43:0] q[$];
        logic ov, ir; logic [31:0] r, a, b; logic [7:0] tg, t; logic [3:0] fl;
        int mw, sent, c;
        longint wmask;
        mw = (cfg == 0) ? 23 : 7;
        wmask = (64'sd1 << (9 + mw)) - 64'sd1;
        sent = 0;
        c = 0;
        while ((sent < n || q.size() > 0) && c < n + 20) begin
            get_out(cfg, ov, r, tg, fl, ir);
            if (ov) begin
                if (q.size() == 0) chk("rnd_extra", {20'h0, tg, fl, r}, 64'h0);
                else chk("rnd_out", {20'h0, tg, fl, r}, {20'h0, q.pop_front()});
            end
            if (sent < n) begin
                a = 32'($urandom() & wmask);
                b = 32'($urandom() & wmask);
                if ($urandom_range(3) != 0) a[mw+7 -: 8] = 8'($urandom_range(60, 190));
                if ($urandom_range(3) != 0) b[mw+7 -: 8] = 8'($urandom_range(60, 190));
                t = 8'($urandom_range(255));
                set_in(cfg, 1'b1, a, b, t);
                q.push_back({t, ref_mul(8, mw, a, b)});
                sent++;
            end else begin
                set_in(cfg, 1'b0, 32'h0, 32'h0, 8'h00);
            end
            tick();
            c++;
        end
        chk("rnd_drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic ov, ir, stall_prev, saw_full, acc;
        logic [31:0] r, hold_r; logic [7:0] tg, hold_t; logic [3:0] fl, hold_f;
        int c, sent, got, occ;

        set_in(0, 1'b0, 32'h0, 32'h0, 8'h00);
        set_in(1, 1'b0, 32'h0, 32'h0, 8'h00);
        b32.out_ready = 1'b1;
        b16.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        get_out(0, ov, r, tg, fl, ir);
        chk("reset_outputs", {ov, tg, fl, r}, 64'h0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 64'(b32.in_ready), 64'd1);

        // Basic latency: accepted at one edge, visible after the third.
        set_in(0, 1'b1, 32'h3FC00000, 32'h40000000, 8'h5A);
        chk("lat_in_ready", 64'(b32.in_ready), 64'd1);
        tick();
        set_in(0, 1'b0, 32'h0, 32'h0, 8'h00);
        chk("lat_c1_idle", 64'(b32.out_valid), 64'd0);
        tick();
        chk("lat_c2_idle", 64'(b32.out_valid), 64'd0);
        tick();
        get_out(0, ov, r, tg, fl, ir);
        chk("lat_c3_result", {ov, tg, fl, r}, {1'b1, 8'h5A, 4'h0, 32'h40400000});
        tick();
        chk("lat_consumed", 64'(b32.out_valid), 64'd0);

        run_op(0, "rne_tie",      32'h3F800001, 32'h3FC00000, 8'h01, 32'h3FC00002, 4'b0001);
        run_op(0, "neg_exact",    32'hBF800000, 32'h40400000, 8'h02, 32'hC0400000, 4'b0000);
        run_op(0, "overflow",     32'h7F000000, 32'h40000000, 8'h03, 32'h7F800000, 4'b0101);
        run_op(0, "underflow",    32'h00800000, 32'h3F000000, 8'h04, 32'h00000000, 4'b0011);
        run_op(0, "underflow_ng", 32'h80800000, 32'h3F000000, 8'h05, 32'h80000000, 4'b0011);
        run_op(0, "inf_x_zero",   32'h7F800000, 32'h00000000, 8'h06, 32'h7FC00000, 4'b1000);
        run_op(0, "snan",         32'h7FA00000, 32'h3F800000, 8'h07, 32'h7FC00000, 4'b1000);
        run_op(0, "qnan",         32'h7FC00001, 32'h3F800000, 8'h08, 32'h7FC00000, 4'b0000);
        run_op(0, "neg_inf",      32'hFF800000, 32'h40000000, 8'h09, 32'hFF800000, 4'b0000);
        run_op(0, "daz",          32'h00000001, 32'h3F800000, 8'h0A, 32'h00000000, 4'b0000);
        run_op(1, "bf16_mul",     32'h3FC0,     32'h4000,     8'h0B, 32'h4040,     4'b0000);
        run_op(1, "bf16_ovf",     32'h7F00,     32'h4000,     8'h0C, 32'h7F80,     4'b0101);

        // Backpressure: 10 back-to-back ops, consumer stalls on cycles 4..8.
        c = 0; sent = 0; got = 0; occ = 0; stall_prev = 1'b0; saw_full = 1'b0;
        hold_r = 32'h0; hold_t = 8'h0; hold_f = 4'h0;
        while (got < 10 && c < 60) begin
            b32.out_ready = !(c >= 4 && c <= 8);
            #0;
            get_out(0, ov, r, tg, fl, ir);
            if (stall_prev) chk("bp_hold", {ov, tg, fl, r}, {1'b1, hold_t, hold_f, hold_r});
            chk("bp_in_ready", 64'(ir), 64'(!(occ == 3 && !b32.out_ready)));
            if (occ == 3 && !b32.out_ready) saw_full = 1'b1;
            if (ov && b32.out_ready) begin
                chk("bp_result", {tg, fl, r},
                    {8'(got), 4'h0, 32'h40000000 | (32'(got) << 19)});
                got++;
                occ--;
            end
            acc = (sent < 10) && ir;
            set_in(0, sent < 10, 32'h3F800000 | (32'(sent) << 19), 32'h40000000, 8'(sent));
            if (acc) begin
                sent++;
                occ++;
            end
            stall_prev = ov && !b32.out_ready;
            hold_r = r; hold_t = tg; hold_f = fl;
            tick();
            c++;
        end
        set_in(0, 1'b0, 32'h0, 32'h0, 8'h00);
        chk("bp_all_delivered", 64'(got), 64'd10);
        chk("bp_full_seen", 64'(saw_full), 64'd1);
        b32.out_ready = 1'b1;
        tick();
        chk("bp_no_duplicate", 64'(b32.out_valid), 64'd0);

        // Reset with three operations in flight.
        b32.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1'b1, 32'h3FC00000, 32'h40000000, 8'(8'h70 + i));
            tick();
        end
        set_in(0, 1'b0, 32'h0, 32'h0, 8'h00);
        chk("rst_pipe_full", 64'(b32.out_valid), 64'd1);
        rst = 1'b1;
        tick();
        get_out(0, ov, r, tg, fl, ir);
        chk("rst_outputs_clear", {ov, tg, fl, r}, 64'h0);
        rst = 1'b0;
        b32.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_stale", 64'(b32.out_valid), 64'd0);
        end
        run_op(0, "rst_new_op", 32'h3FC00000, 32'h40000000, 8'h33, 32'h40400000, 4'b0000);

        rand_run(0, 300);
        rand_run(1, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready handshaking, round-to-nearest-even and exception flags. It generalises the datapath's combinational FP32 multiplier to any exponent/mantissa width (FP32, BF16, FP16, …) and fits into streaming MAC and scaling paths. Throughput is one operation per cycle, with full backpressure support and an opaque tag carried alongside each operation.

## Interface
- EXP_W, 8, exponent field width (≥4); bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width (≥3); word width W = 1+EXP_W+MAN_W
- TAG_W, 8, sideband tag width (≥1)
- clk  in  1  clock; everything is synchronous to the rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept; combinational from out_ready and the stage valids
- in_a, in_b  in  W  operands {sign, exp, frac}
- in_tag  in  TAG_W  sideband; returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  W  product
- out_tag  out  TAG_W  tag of this result
- out_flags  out  4  {invalid, overflow, underflow, inexact}

## Operation
- Transfer happens when valid && ready on the respective side. The result order matches the input order. There is no combinational path from in_valid/in_a/in_b to any output.
- Stage 1, unpack:
  - Detect zero, inf, qNaN and sNaN (an sNaN has frac MSB = 0 and frac ≠ 0).
  - Subnormal inputs are treated as signed zero (DAZ).
  - sign = sa^sb.
  - Signed exponent sum e = ea + eb − bias, computed at EXP_W+2 bits.
- Stage 2, multiply: integer product of the two significands {1, frac} (MAN_W+1 bits each), giving a 2·MAN_W+2 bit product.
- Stage 3, normalise/round/pack:
  - If the product MSB is set, shift right by 1 and add 1 to e.
  - Round to nearest even using guard and sticky bits.
  - If rounding carries out of the significand, shift right and add 1 to e again.
- Special-case priority, highest first:
  1. Any NaN operand, or inf×0 → canonical NaN {0, all-ones, 1, 0…}. invalid=1 if either operand is sNaN or the case is inf×0.
  2. Inf operand → signed inf, flags 0.
  3. Zero operand (including DAZ) → signed zero, flags 0.
  4. Final e ≥ 2^EXP_W−1 → signed inf, overflow=1, inexact=1.
  5. Final e ≤ 0 → signed zero (FTZ), underflow=1, inexact=1.
  6. Otherwise normal pack; inexact = guard|sticky.
- Flags belong to the result; they are not sticky across operations.

## Timing
- Three register stages. Latency is 3 cycles from an input handshake to out_valid when unstalled. Throughput is 1/cycle.
- Stage k loads when it is empty or its contents advance this cycle.
  - Stage 3 advances on out_ready.
  - in_ready = !v1 | (advance of stage 1).
  - Bubbles collapse: an empty stage accepts even while a later stage is stalled.
- While stalled, out_result, out_tag and out_flags are held stable and out_valid stays high until the handshake.
- Full: all three stages valid with out_ready=0 drives in_ready=0 in the same cycle. Simultaneous out_ready=1 with a full pipe gives in_ready=1, so a new input is accepted in the same cycle.
- Reset:
  - All stage valids clear the next cycle. out_valid=0, out_result=0, out_tag=0, out_flags=0.
  - In-flight operations are discarded with no partial output.
  - in_ready=1 from the first cycle after reset deasserts.

## Test plan
All values are FP32 (default parameters).
- Basic latency: 0x3FC00000 × 0x40000000, tag 0x5A, out_ready=1 → exactly 3 cycles later, out_result=0x40400000, out_tag=0x5A, flags=0.
- RNE tie: 0x3F800001 × 0x3FC00000 → 0x3FC00002, inexact=1. Also 0xBF800000 × 0x40400000 → 0xC0400000, flags=0.
- Overflow and underflow:
  - 0x7F000000 × 0x40000000 → 0x7F800000, overflow=1, inexact=1.
  - 0x00800000 × 0x3F000000 → 0x00000000, underflow=1, inexact=1.
  - 0x80800000 × 0x3F000000 → 0x80000000.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0x7FA00000 × 0x3F800000 → 0x7FC00000, invalid=1.
  - 0x7FC00001 × 0x3F800000 → 0x7FC00000, invalid=0.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
  - Subnormal 0x00000001 × 0x3F800000 → 0x00000000, flags=0.
- Backpressure: stream 10 ops with tags 0..9 back-to-back; hold out_ready=0 for cycles 4–8 → in_ready drops once the three stages are full, and all 10 results emerge in tag order with none lost or duplicated. Outputs stay stable while stalled.
- Reset mid-stream: assert rst for 1 cycle with 3 ops in flight → out_valid=0 and all outputs 0 next cycle, no stale result afterwards, and a new op gives its result 3 cycles after acceptance.
- Parameter sweep: EXP_W=8, MAN_W=7 (BF16): 0x3FC0 × 0x4000 → 0x4040; 0x7F00 × 0x4000 → 0x7F80 with overflow. Randomised compare against a reference model for both configurations.
